uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, with a
// valid/ready holding register for the received byte.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] data_out,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  localparam logic [15:0] MID  = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic        r_sync1;
  logic        r_rx_s;
  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_par_calc;

  logic        r_rx_valid;
  logic [7:0]  r_data_out;
  logic        r_parity_err;
  logic        r_frame_err;
  logic        r_overrun;

  logic w_tick;
  logic w_complete;
  logic w_stop_bad;
  logic w_accept;

  assign w_tick     = (r_cnt == LAST);
  assign w_complete = (r_state == STOP) && w_tick && r_rx_s;
  assign w_stop_bad = (r_state == STOP) && w_tick && !r_rx_s;
  assign w_accept   = r_rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_calc <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) r_state <= START;
        end
        START: begin
          // A line that is high again at mid-start is a glitch, not a frame.
          if (r_cnt == MID) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= r_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            if (r_idx == 3'd7) r_state <= PARITY;
            else               r_idx   <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_cnt      <= '0;
            r_par_calc <= r_rx_s ^ (^r_shift);
            r_state    <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= r_rx_s ? IDLE : WAIT_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (r_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_valid   <= 1'b0;
      r_data_out   <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= 1'b0;
      // A completion in the same cycle as an accept replaces the held byte.
      if (w_complete) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_valid   <= 1'b1;
          r_data_out   <= r_shift;
          r_parity_err <= r_par_calc;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_valid   = r_rx_valid;
  assign data_out   = r_data_out;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != IDLE);

endmodule
